// File: rtl/seg7_scan_if.sv
// Bundle of display-side signals between the value source and the scanner.
// The master modport belongs to whoever supplies the value and the scan controls;
// the slave modport belongs to the scanner.
//   value_in  : DIGITS nibbles; nibble k is digit k, and digit 0 is least significant
//   load_in   : one-cycle strobe that captures value_in into the shadow register
//   en_in     : scan enable (low = display dark)
//   lzb_in    : leading-zero blanking enable
//   num_out   : nibble for the current digit, sent to the 7-segment decoder
//   dig_out   : active-low digit selects; at most one is low at any time
//   blank_out : high = current digit suppressed
//   tick_out  : one-cycle pulse on every DRIVE entry
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [4*DIGITS-1:0] value_in;
  logic                load_in;
  logic                en_in;
  logic                lzb_in;
  logic [3:0]          num_out;
  logic [DIGITS-1:0]   dig_out;
  logic                blank_out;
  logic                tick_out;

  modport master (
    output value_in, load_in, en_in, lzb_in,
    input  num_out, dig_out, blank_out, tick_out
  );

  modport slave (
    input  value_in, load_in, en_in, lzb_in,
    output num_out, dig_out, blank_out, tick_out
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner. The scanner shows one digit at a time from a
// shadowed display value. Between digits it inserts a dark guard interval.
// It can also blank leading zeros.
//   clk_in : system clock (rising edge)
//   rst_in : asynchronous active-high reset
//   bus    : seg7_scan_if slave (value/load/en/lzb in; num/dig/blank/tick out)
module seg7_scan #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  seg7_scan_if.slave  bus
);

  localparam int unsigned MAX_C = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int unsigned CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   shadow_q, shadow_d;
  logic [3:0]         num_q, num_d;
  logic [DIGITS-1:0]  dig_q, dig_d;
  logic               blank_q, blank_d;
  logic               tick_q, tick_d;

  logic               guard_entry;
  logic [IDX_W-1:0]   entry_idx;
  logic [3:0]         sel_nib;
  logic               upper_nz;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_d       = num_q;
    dig_d       = dig_q;
    blank_d     = blank_q;
    tick_d      = 1'b0;
    shadow_d    = bus.load_in ? bus.value_in : shadow_q;
    guard_entry = 1'b0;
    entry_idx   = idx_q;
    sel_nib     = 4'h0;
    upper_nz    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en_in) begin
          state_d     = ST_GUARD;
          guard_entry = 1'b1;
          entry_idx   = '0;
        end
      end
      ST_GUARD: begin
        if (!bus.en_in) begin
          state_d = ST_IDLE;
          dig_d   = '1;
          blank_d = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          tick_d  = 1'b1;
          dig_d   = '1;
          // A blanked digit keeps every select high for the whole slot
          if (!blank_q) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
              if (IDX_W'(k) == idx_q) dig_d[k] = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (!bus.en_in) begin
          state_d = ST_IDLE;
          dig_d   = '1;
          blank_d = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d     = ST_GUARD;
          guard_entry = 1'b1;
          entry_idx   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dig_d   = '1;
        blank_d = 1'b1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Nibble and zero test come from shadow_q before this edge's load,
    // so a load that lands on a GUARD entry only takes effect at the next slot
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (IDX_W'(k) == entry_idx) sel_nib = shadow_q[4*k +: 4];
      if (IDX_W'(k) >= entry_idx && shadow_q[4*k +: 4] != 4'h0) upper_nz = 1'b1;
    end

    if (guard_entry) begin
      idx_d   = entry_idx;
      num_d   = sel_nib;
      blank_d = bus.lzb_in && (entry_idx != '0) && !upper_nz;
      dig_d   = '1;
      cnt_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      num_q    <= 4'h0;
      dig_q    <= '1;
      blank_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      num_q    <= num_d;
      dig_q    <= dig_d;
      blank_q  <= blank_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.num_out   = num_q;
  assign bus.dig_out   = dig_q;
  assign bus.blank_out = blank_q;
  assign bus.tick_out  = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan with DIGITS=4, DIV=8 and BLANK_CYC=2.
// A reference model tracks the position within the frame and reports the
// expected outputs on every cycle. At each slot start it pushes the expected
// digit into a scoreboard queue. A monitor pops that queue on every tick_out.
module tb_seg7_scan;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int SLOT   = DIV + BLANK;

  typedef struct {
    logic [3:0] dig;
    logic [3:0] num;
    logic       blank;
  } exp_t;

  logic clk;
  logic rst;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int ticks_seen = 0;
  int ticks_exp  = 0;

  exp_t sbq[$];

  // Expected outputs from the model
  int         p;
  logic [15:0] m_shadow;
  logic [3:0] e_num;
  logic [3:0] e_dig;
  logic       e_blank;
  logic       e_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-position model: p counts cycles since the scan started (-1 = idle)
  always @(posedge clk or posedge rst) begin
    int   ph;
    int   d;
    exp_t e;
    if (rst) begin
      p = -1; m_shadow = 16'h0; e_num = 4'h0; e_blank = 1'b1;
      e_tick = 1'b0; e_dig = 4'hF; sbq.delete();
    end else begin
      e_tick = 1'b0;
      if (p < 0) begin
        if (bus.en_in) p = 0;
      end else if (!bus.en_in) begin
        p = -1;
        sbq.delete();
      end else begin
        p++;
      end
      if (p < 0) begin
        e_blank = 1'b1;
        e_dig   = 4'hF;
      end else begin
        ph = p % SLOT;
        d  = (p / SLOT) % DIGITS;
        if (ph == 0) begin
          e_num   = 4'((m_shadow >> (4*d)) & 16'hF);
          e_blank = bus.lzb_in && (d != 0) && ((m_shadow >> (4*d)) == 16'h0);
          e_dig   = 4'hF;
          e.num   = e_num;
          e.blank = e_blank;
          e.dig   = e_blank ? 4'hF : ~(4'b1 << d);
          sbq.push_back(e);
        end else if (ph == BLANK) begin
          e_tick = 1'b1;
          e_dig  = e_blank ? 4'hF : ~(4'b1 << d);
          ticks_exp++;
        end
      end
      if (bus.load_in) m_shadow = bus.value_in;
    end
  end

  // Monitor: checks every cycle, plus a scoreboard pop on each tick
  always @(negedge clk) begin
    exp_t e;
    chk("dig_out", 32'(bus.dig_out), 32'(e_dig));
    chk("num_out", 32'(bus.num_out), 32'(e_num));
    chk("blank_out", 32'(bus.blank_out), 32'(e_blank));
    chk("tick_out", 32'(bus.tick_out), 32'(e_tick));
    if (bus.tick_out === 1'b1) begin
      ticks_seen++;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: tick with no pending slot at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("sb_num", 32'(bus.num_out), 32'(e.num));
        chk("sb_blank", 32'(bus.blank_out), 32'(e.blank));
        chk("sb_dig", 32'(bus.dig_out), 32'(e.dig));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    bus.value_in = v;
    bus.load_in  = 1'b1;
    @(negedge clk);
    bus.load_in  = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    logic [15:0] v;
    int          s;
    rst = 1'b1;
    bus.value_in = 16'h0;
    bus.load_in  = 1'b0;
    bus.en_in    = 1'b0;
    bus.lzb_in   = 1'b0;
    step(3);
    chk("rst_dig", 32'(bus.dig_out), 32'hF);
    chk("rst_num", 32'(bus.num_out), 32'h0);
    chk("rst_blank", 32'(bus.blank_out), 32'h1);
    chk("rst_tick", 32'(bus.tick_out), 32'h0);
    rst = 1'b0;
    step(2);

    // Basic scan, no blanking
    load(16'h1234);
    bus.en_in = 1'b1;
    step(100);

    // Leading-zero blanking
    bus.lzb_in = 1'b1;
    load(16'h0050);
    step(80);
    load(16'h0000);
    step(80);

    // Mid-slot reload
    bus.lzb_in = 1'b0;
    load(16'h1234);
    step(53);
    load(16'hABCD);
    step(60);

    // Enable drop and re-raise
    step(7);
    bus.en_in = 1'b0;
    step(4);
    bus.en_in = 1'b1;
    step(40);

    // Asynchronous reset mid-slot
    step(17);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dig", 32'(bus.dig_out), 32'hF);
    chk("arst_num", 32'(bus.num_out), 32'h0);
    chk("arst_blank", 32'(bus.blank_out), 32'h1);
    chk("arst_tick", 32'(bus.tick_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(45);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        s    = $urandom_range(0, 4);
        mask = 16'hFFFF >> (4*s);
        v    = 16'($urandom) & mask;
        bus.value_in = v;
        bus.load_in  = 1'b1;
      end else begin
        bus.load_in  = 1'b0;
      end
      if ($urandom_range(0, 99) < 3) bus.lzb_in = ~bus.lzb_in;
      if (bus.en_in && $urandom_range(0, 299) == 0) bus.en_in = 1'b0;
      else if (!bus.en_in && $urandom_range(0, 9) == 0) bus.en_in = 1'b1;
      step(1);
    end
    bus.load_in = 1'b0;
    step(2);

    chk("tick_count", 32'(ticks_seen), 32'(ticks_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
